exception_unit: RTL
===================

# exception_unit

Collects synchronous exception requests from the IF, ID, EX and MEM pipeline stages, plus an optional external interrupt, and resolves them to a single precise trap. It sits directly upstream of coprocessor 0 and drives that block's 35-bit `exception_bus` input. It also drives the pipeline flush lines and the fetch-PC redirect for both trap entry and `eret` return.

## Interface
- `EXC_VECTOR`, default 32'h8000_0180: trap handler address driven on `pc_target` at trap entry.

- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high.
- `if_exc_addr` input 1: instruction fetch address error; `if_pc` input 32: its PC.
- `id_exc_ri` input 1: reserved instruction.
- `id_exc_sys` input 1: syscall.
- `id_pc` input 32: PC of the ID instruction.
- `ex_exc_ov` input 1: arithmetic overflow; `ex_pc` input 32: its PC.
- `mem_exc_addr` input 1: data address error; `mem_pc` input 32: its PC.
- `eret` input 1: `eret` instruction in MEM.
- `epc_in` input 32: current EPC from coprocessor 0.
- `status_ie` input 1: interrupt enable (SR bit 0).
- `irq` input 1: asynchronous external interrupt request.
- `exception_bus` output 35: {code[34:32], epc[31:0]}. Code 0 means no exception.
- `flush_if`, `flush_id`, `flush_ex`, `flush_mem` output 1 each: squash the stage register.
- `pc_redirect` output 1: the fetch stage loads `pc_target` on this cycle.
- `pc_target` output 32: redirect address.

## Operation
- Exception codes:
  - 1: interrupt
  - 2: fetch address error
  - 3: reserved instruction
  - 4: syscall
  - 5: overflow
  - 6: data address error
  - 7: reserved, never driven.
- Priority, oldest stage first: 6 > 5 > 3 > 4 > 2 > 1. The winner's stage PC becomes the EPC. An interrupt uses `ex_pc`.
- Flush scope: a trap at stage S flushes S and every younger stage.
  - MEM: all four flush lines.
  - EX: IF, ID and EX.
  - ID: IF and ID.
  - IF: IF only.
  - Interrupt: same as EX.
- FSM states IDLE, TRAP, HOLD.
  - IDLE, any enabled request present → TRAP. The winner is latched and outputs are registered.
  - IDLE, no request and `eret`=1 → HOLD. At the same time register `pc_redirect`=1, `pc_target`=`epc_in`, and `flush_if`/`flush_id`/`flush_ex`=1.
  - An exception present in the same cycle as `eret` wins; `eret` is dropped.
  - TRAP (exactly 1 cycle): `exception_bus` = latched {code, epc}, latched flush lines asserted, `pc_redirect`=1, `pc_target`=`EXC_VECTOR`. Next state: HOLD.
  - HOLD (exactly 1 cycle): all outputs 0. All request inputs are ignored while bubbles drain. Next state: IDLE.
- `exception_bus`, the flush lines and `pc_redirect` are zero in every cycle not listed above.
- `pc_target` holds its last value when `pc_redirect`=0.

## Timing
- All outputs are registered. Inputs sampled at edge N appear on the outputs from edge N to edge N+1 for exactly one cycle. Latency is 1 cycle.
- Minimum spacing between two traps is 3 cycles: IDLE→TRAP→HOLD→IDLE.
- Coprocessor 0 treats the bus as valid when code ≠ 0. No acknowledge is required.
- Reset, asynchronous and at any time including mid-TRAP or mid-HOLD:
  - State goes to IDLE.
  - `exception_bus`=35'd0.
  - All flush lines 0.
  - `pc_redirect`=0, `pc_target`=32'd0.
  - Interrupt synchronizer flops are cleared to 0.
- Request inputs are level-sampled. A request still held after HOLD is re-taken. Upstream stages are responsible for clearing it by flush.

## Configuration
- `EXC_INTERRUPT_EN` defined:
  - `irq` passes through a 2-flop synchronizer.
  - The synchronized level AND `status_ie` raises a code-1 request at the lowest priority.
  - Earliest trap is 3 edges after `irq` rises.
- Not defined:
  - The synchronizer is absent.
  - `irq` and `status_ie` are ignored.
  - Code 1 is never produced.
  - All other behaviour is identical.

## Test plan
- `mem_exc_addr`=1, `mem_pc`=32'h0040_0010 for 1 cycle → next cycle: `exception_bus`={3'd6, 32'h0040_0010}, all four flush lines 1, `pc_redirect`=1, `pc_target`=32'h8000_0180. Following cycle: all zero.
- `ex_exc_ov` and `id_exc_sys` asserted together, `ex_pc`=32'h100 → code 5, EPC 32'h100. `flush_if`/`flush_id`/`flush_ex`=1, `flush_mem`=0.
- `eret`=1, `epc_in`=32'h0040_0020, no exception → next cycle: `pc_redirect`=1, `pc_target`=32'h0040_0020, IF/ID/EX flushed, `exception_bus`=0. The same stimulus with `if_exc_addr`=1 → code 2 trap and the `eret` is ignored.
- `id_exc_ri` held high for 5 cycles → traps in cycle 1 and cycle 4 only. HOLD suppresses the request in cycles 2–3.
- With `EXC_INTERRUPT_EN`: `irq`=1, `status_ie`=1, `ex_pc`=32'h200 → code 1, EPC 32'h200 on the 3rd cycle. With `status_ie`=0 → no trap. Without the macro → no trap.
- Assert `reset` asynchronously during TRAP → all outputs 0 immediately, without waiting for a clock edge. State is IDLE after release.

Source files
------------

// File: rtl/exception_unit.sv
// exception_unit: resolves IF/ID/EX/MEM exception requests and an optional
// external interrupt to one precise trap. It drives the coprocessor 0
// exception bus, the pipeline flush lines and the fetch-PC redirect for
// trap entry and eret return.
// Optional feature macro: EXC_INTERRUPT_EN (2-flop irq synchronizer plus a
// code-1 interrupt request gated by status_ie). When the macro is undefined,
// irq and status_ie are ignored.
module exception_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_exc_addr,
  input  logic [31:0] if_pc,
  input  logic        id_exc_ri,
  input  logic        id_exc_sys,
  input  logic [31:0] id_pc,
  input  logic        ex_exc_ov,
  input  logic [31:0] ex_pc,
  input  logic        mem_exc_addr,
  input  logic [31:0] mem_pc,
  input  logic        eret,
  input  logic [31:0] epc_in,
  input  logic        status_ie,
  input  logic        irq,
  output logic [34:0] exception_bus,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        flush_mem,
  output logic        pc_redirect,
  output logic [31:0] pc_target
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRAP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [34:0] exc_bus_q, exc_bus_d;
  logic [3:0]  flush_q, flush_d;       // {mem, ex, id, if}
  logic        pc_redirect_q, pc_redirect_d;
  logic [31:0] pc_target_q, pc_target_d;

  logic        irq_req;
  logic [2:0]  win_code;
  logic [31:0] win_epc;
  logic [3:0]  win_flush;

`ifdef EXC_INTERRUPT_EN
  logic irq_sync1_q, irq_sync1_d;
  logic irq_sync2_q, irq_sync2_d;

  // Synchronizer next values: irq is asynchronous to clk.
  always_comb begin
    irq_sync1_d = irq;
    irq_sync2_d = irq_sync1_q;
  end

  // Two-flop synchronizer chain for the external interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_sync1_q <= 1'b0;
      irq_sync2_q <= 1'b0;
    end else begin
      irq_sync1_q <= irq_sync1_d;
      irq_sync2_q <= irq_sync2_d;
    end
  end

  assign irq_req = irq_sync2_q & status_ie;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = irq ^ status_ie;
  assign irq_req = 1'b0;
`endif

  // Pick the oldest-stage request; its PC becomes the EPC and it sets the flush scope.
  always_comb begin
    win_code  = 3'd0;
    win_epc   = 32'd0;
    win_flush = 4'b0000;
    if (mem_exc_addr) begin
      win_code  = 3'd6;
      win_epc   = mem_pc;
      win_flush = 4'b1111;
    end else if (ex_exc_ov) begin
      win_code  = 3'd5;
      win_epc   = ex_pc;
      win_flush = 4'b0111;
    end else if (id_exc_ri) begin
      win_code  = 3'd3;
      win_epc   = id_pc;
      win_flush = 4'b0011;
    end else if (id_exc_sys) begin
      win_code  = 3'd4;
      win_epc   = id_pc;
      win_flush = 4'b0011;
    end else if (if_exc_addr) begin
      win_code  = 3'd2;
      win_epc   = if_pc;
      win_flush = 4'b0001;
    end else if (irq_req) begin
      // An interrupt is taken on the EX instruction.
      win_code  = 3'd1;
      win_epc   = ex_pc;
      win_flush = 4'b0111;
    end
  end

  // Next state and next registered outputs; outputs default to idle values.
  always_comb begin
    state_d       = state_q;
    exc_bus_d     = 35'd0;
    flush_d       = 4'b0000;
    pc_redirect_d = 1'b0;
    pc_target_d   = pc_target_q;
    case (state_q)
      IDLE: begin
        if (win_code != 3'd0) begin
          // A trap beats an eret arriving in the same cycle.
          state_d       = TRAP;
          exc_bus_d     = {win_code, win_epc};
          flush_d       = win_flush;
          pc_redirect_d = 1'b1;
          pc_target_d   = EXC_VECTOR;
        end else if (eret) begin
          state_d       = HOLD;
          flush_d       = 4'b0111;
          pc_redirect_d = 1'b1;
          pc_target_d   = epc_in;
        end
      end
      TRAP:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      exc_bus_q     <= 35'd0;
      flush_q       <= 4'b0000;
      pc_redirect_q <= 1'b0;
      pc_target_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      exc_bus_q     <= exc_bus_d;
      flush_q       <= flush_d;
      pc_redirect_q <= pc_redirect_d;
      pc_target_q   <= pc_target_d;
    end
  end

  assign exception_bus = exc_bus_q;
  assign flush_if      = flush_q[0];
  assign flush_id      = flush_q[1];
  assign flush_ex      = flush_q[2];
  assign flush_mem     = flush_q[3];
  assign pc_redirect   = pc_redirect_q;
  assign pc_target     = pc_target_q;

endmodule
